// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game control block.
package snake_pkg;

  localparam logic [2:0] ST_START = 3'b001;
  localparam logic [2:0] ST_PLAY  = 3'b010;
  localparam logic [2:0] ST_END   = 3'b100;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_GRID_W       = 40;
  localparam int DEF_GRID_H       = 30;
  localparam int DEF_BONUS_PERIOD = 5;

  typedef enum logic [2:0] {
    S_START = ST_START,
    S_PLAY  = ST_PLAY,
    S_END   = ST_END
  } game_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter; emits a one-cycle press when the
// accepted level goes high->low. Event lags the raw edge by sync + DEBOUNCE_CYCLES + 1.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
      press  <= 1'b0;
      // Any sample that agrees with the accepted level restarts the count.
      if (sync_b != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_b;
          cnt   <= '0;
          press <= ~sync_b;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control: start-key debounce, START/PLAY/END sequencing, eat/collision detection
// and LFSR apple placement. All outputs registered; status follows its trigger by one cycle.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int END_HOLD_CYCLES   = 150_000_000,
  parameter int BODY_PULSE_CYCLES = 4,
  parameter int GRID_W            = DEF_GRID_W,
  parameter int GRID_H            = DEF_GRID_H,
  parameter int BONUS_PERIOD      = DEF_BONUS_PERIOD
) (
  input  logic       Clk_50mhz,
  input  logic       Rst_n,
  input  logic       Key_start_n,
  input  logic       Step_tick,
  input  logic [5:0] Head_x,
  input  logic [4:0] Head_y,
  input  logic       Hit_wall,
  input  logic       Hit_body,
  output logic [2:0] Game_status,
  output logic       Body_add_sig,
  output logic       Apple_type,
  output logic [5:0] Apple_x,
  output logic [4:0] Apple_y,
  output logic       Apple_valid
);

  localparam int PW = $clog2(BODY_PULSE_CYCLES + 1);
  localparam int EW = (BONUS_PERIOD > 1) ? $clog2(BONUS_PERIOD) : 1;
  localparam int HW = $clog2(END_HOLD_CYCLES + 1);

  localparam logic [5:0] HOME_X   = 6'(GRID_W / 2 + 10);
  localparam logic [4:0] HOME_Y   = 5'(GRID_H / 2);
  localparam logic [5:0] MID_X    = 6'(GRID_W / 2);
  localparam logic [4:0] MID_Y    = 5'(GRID_H / 2);
  localparam logic [6:0] GRID_W_L = 7'(GRID_W);
  localparam logic [5:0] GRID_H_L = 6'(GRID_H);

  game_state_t   state;
  logic          press;
  logic [15:0]   lfsr;
  logic [EW-1:0] eat_cnt;
  logic [EW-1:0] eat_nxt;
  logic [PW-1:0] pulse_cnt;
  logic [HW-1:0] end_cnt;
  logic [3:0]    search_cnt;
  logic          searching;
  logic          pending_type;

  logic          hit;
  logic          eat;
  logic [5:0]    cand_x;
  logic [4:0]    cand_y;
  logic          cand_ok;
  logic          mid_is_head;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_start (
    .clk  (Clk_50mhz),
    .rst_n(Rst_n),
    .key_n(Key_start_n),
    .press(press)
  );

  assign Game_status = state;
  assign hit         = Hit_wall | Hit_body;
  // Apple_valid is low during the pulse and the search, so late ticks never re-eat.
  assign eat         = (state == S_PLAY) && Step_tick && !hit && Apple_valid &&
                       (Head_x == Apple_x) && (Head_y == Apple_y);
  assign eat_nxt     = (eat_cnt == EW'(BONUS_PERIOD - 1)) ? '0 : eat_cnt + EW'(1);

  assign cand_x      = lfsr[5:0];
  assign cand_y      = lfsr[12:8];
  assign cand_ok     = ({1'b0, cand_x} < GRID_W_L) && ({1'b0, cand_y} < GRID_H_L) &&
                       !((cand_x == Head_x) && (cand_y == Head_y));
  assign mid_is_head = (Head_x == MID_X) && (Head_y == MID_Y);

  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= S_START;
      lfsr         <= LFSR_SEED;
      eat_cnt      <= '0;
      pulse_cnt    <= '0;
      end_cnt      <= '0;
      search_cnt   <= '0;
      searching    <= 1'b0;
      pending_type <= 1'b0;
      Body_add_sig <= 1'b0;
      Apple_type   <= 1'b0;
      Apple_x      <= HOME_X;
      Apple_y      <= HOME_Y;
      Apple_valid  <= 1'b1;
    end else begin
      lfsr <= lfsr_next(lfsr);
      case (state)
        S_START: begin
          if (press) begin
            state        <= S_PLAY;
            Apple_x      <= HOME_X;
            Apple_y      <= HOME_Y;
            Apple_type   <= 1'b0;
            Apple_valid  <= 1'b1;
            eat_cnt      <= '0;
            Body_add_sig <= 1'b0;
            searching    <= 1'b0;
          end
        end
        S_PLAY: begin
          if (Step_tick && hit) begin
            // Collision wins over eating and cancels any pulse or search in flight.
            state        <= S_END;
            end_cnt      <= '0;
            Body_add_sig <= 1'b0;
            pulse_cnt    <= '0;
            searching    <= 1'b0;
            Apple_valid  <= 1'b1;
          end else if (eat) begin
            Body_add_sig <= 1'b1;
            pulse_cnt    <= '0;
            Apple_valid  <= 1'b0;
            eat_cnt      <= eat_nxt;
            pending_type <= (eat_nxt == EW'(BONUS_PERIOD - 1));
          end else if (Body_add_sig) begin
            if (pulse_cnt == PW'(BODY_PULSE_CYCLES - 1)) begin
              Body_add_sig <= 1'b0;
              searching    <= 1'b1;
              search_cnt   <= '0;
            end else begin
              pulse_cnt <= pulse_cnt + PW'(1);
            end
          end else if (searching) begin
            if (cand_ok) begin
              Apple_x     <= cand_x;
              Apple_y     <= cand_y;
              Apple_type  <= pending_type;
              Apple_valid <= 1'b1;
              searching   <= 1'b0;
            end else if (search_cnt == 4'd15) begin
              Apple_x     <= mid_is_head ? 6'd0 : MID_X;
              Apple_y     <= mid_is_head ? 5'd0 : MID_Y;
              Apple_type  <= pending_type;
              Apple_valid <= 1'b1;
              searching   <= 1'b0;
            end else begin
              search_cnt <= search_cnt + 4'd1;
            end
          end
        end
        S_END: begin
          if (press || (end_cnt == HW'(END_HOLD_CYCLES - 1))) begin
            state <= S_START;
          end else begin
            end_cnt <= end_cnt + HW'(1);
          end
        end
        default: state <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomized self-checking bench for snake_game_ctrl against a small game-rule model.
module tb_snake_game_ctrl;

  localparam int DEB   = 8;
  localparam int HOLD  = 20;
  localparam int PULSE = 4;
  localparam int GW    = 40;
  localparam int GH    = 30;
  localparam int BONUS = 5;
  localparam int ST_S  = 1;
  localparam int ST_P  = 2;
  localparam int ST_E  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic       step;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic       hit_wall;
  logic       hit_body;
  logic [2:0] status;
  logic       body_add;
  logic       apple_type;
  logic [5:0] apple_x;
  logic [4:0] apple_y;
  logic       apple_valid;

  int n_checks = 0;
  int n_errors = 0;
  int m_eat_cnt;
  bit m_type;
  int lat0;

  snake_game_ctrl #(
    .DEBOUNCE_CYCLES  (DEB),
    .END_HOLD_CYCLES  (HOLD),
    .BODY_PULSE_CYCLES(PULSE),
    .GRID_W           (GW),
    .GRID_H           (GH),
    .BONUS_PERIOD     (BONUS)
  ) dut (
    .Clk_50mhz   (clk),
    .Rst_n       (rst_n),
    .Key_start_n (key_n),
    .Step_tick   (step),
    .Head_x      (head_x),
    .Head_y      (head_y),
    .Hit_wall    (hit_wall),
    .Hit_body    (hit_body),
    .Game_status (status),
    .Body_add_sig(body_add),
    .Apple_type  (apple_type),
    .Apple_x     (apple_x),
    .Apple_y     (apple_y),
    .Apple_valid (apple_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input int hx, input int hy, input bit w, input bit b);
    head_x   = 6'(hx);
    head_y   = 5'(hy);
    hit_wall = w;
    hit_body = b;
    step     = 1'b1;
    tick();
    step     = 1'b0;
    hit_wall = 1'b0;
    hit_body = 1'b0;
  endtask

  // Drop the key and count edges until the status reaches target.
  task automatic press_until(input int target, output int lat);
    key_n = 1'b0;
    lat   = 0;
    while (int'(status) != target && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic enter_play(input string tag);
    int lat;
    press_until(ST_P, lat);
    check_eq({tag, "_status"}, int'(status), ST_P);
    key_n = 1'b1;
    repeat (15) tick();
    m_eat_cnt = 0;
    m_type    = 1'b0;
    check_eq({tag, "_apple_x"}, int'(apple_x), GW / 2 + 10);
    check_eq({tag, "_apple_y"}, int'(apple_y), GH / 2);
    check_eq({tag, "_type"}, int'(apple_type), 0);
    check_eq({tag, "_valid"}, int'(apple_valid), 1);
  endtask

  task automatic eat_apple(input bit extra_step);
    int ax, ay, hx, hy, hi, wc;
    bit exp_type, type_ok;
    repeat ($urandom_range(0, 7)) tick();
    hx = $urandom_range(0, GW - 1);
    hy = $urandom_range(0, GH - 1);
    if (hx == int'(apple_x) && hy == int'(apple_y)) hx = (hx + 1) % GW;
    do_step(hx, hy, 1'b0, 1'b0);
    check_eq("decoy_no_pulse", int'(body_add), 0);
    check_eq("decoy_valid", int'(apple_valid), 1);
    ax       = int'(apple_x);
    ay       = int'(apple_y);
    exp_type = m_type;
    check_eq("type_before_eat", int'(apple_type), int'(exp_type));
    do_step(ax, ay, 1'b0, 1'b0);
    m_eat_cnt = (m_eat_cnt + 1) % BONUS;
    m_type    = (m_eat_cnt == BONUS - 1);
    check_eq("pulse_rise", int'(body_add), 1);
    check_eq("valid_drop", int'(apple_valid), 0);
    hi      = 0;
    type_ok = 1'b1;
    while (body_add && hi < 20) begin
      if (apple_type !== exp_type) type_ok = 1'b0;
      if (extra_step && hi == 1) do_step(ax, ay, 1'b0, 1'b0);
      else tick();
      hi++;
    end
    check_eq("pulse_width", hi, PULSE);
    check_eq("type_held_in_pulse", int'(type_ok), 1);
    wc = 0;
    while (!apple_valid && wc < 40) begin
      tick();
      wc++;
    end
    check_eq("placed_valid", int'(apple_valid), 1);
    check_eq("placed_in_grid", int'(int'(apple_x) < GW && int'(apple_y) < GH), 1);
    check_eq("placed_not_head", int'(int'(apple_x) != ax || int'(apple_y) != ay), 1);
    check_eq("placed_type", int'(apple_type), int'(m_type));
    check_eq("still_play", int'(status), ST_P);
  endtask

  initial begin
    int dur, ax, ay;
    bit saw_body;
    rst_n = 1'b0; key_n = 1'b1; step = 1'b0;
    head_x = '0; head_y = '0; hit_wall = 1'b0; hit_body = 1'b0;
    repeat (3) tick();
    check_eq("rst_status", int'(status), ST_S);
    check_eq("rst_body", int'(body_add), 0);
    check_eq("rst_type", int'(apple_type), 0);
    check_eq("rst_valid", int'(apple_valid), 1);
    check_eq("rst_apple_x", int'(apple_x), 30);
    check_eq("rst_apple_y", int'(apple_y), 15);
    rst_n = 1'b1;
    repeat (4) tick();

    // Bounces shorter than the debounce window are ignored.
    for (int i = 0; i < 4; i++) begin
      key_n = 1'b0; repeat (3) tick();
      key_n = 1'b1; repeat (3) tick();
    end
    repeat (12) tick();
    check_eq("bounce_ignored", int'(status), ST_S);

    press_until(ST_P, lat0);
    check_eq("start_to_play", int'(status), ST_P);
    check_eq("press_latency_range", int'(lat0 >= DEB + 2 && lat0 <= DEB + 4), 1);
    repeat (30) tick();
    check_eq("held_in_play", int'(status), ST_P);
    m_eat_cnt = 0;
    m_type    = 1'b0;
    check_eq("play_apple_x", int'(apple_x), 30);
    check_eq("play_apple_y", int'(apple_y), 15);
    check_eq("play_type", int'(apple_type), 0);
    key_n = 1'b1;
    repeat (20) tick();

    for (int i = 1; i <= 6; i++) begin
      if (i == 5) check_eq("fifth_apple_bonus", int'(apple_type), 1);
      eat_apple(i == 2);
    end

    // Head on apple together with a body hit: collision wins.
    ax = int'(apple_x);
    ay = int'(apple_y);
    do_step(ax, ay, 1'($urandom_range(0, 1)), 1'b1);
    check_eq("collide_status", int'(status), ST_E);
    check_eq("collide_no_pulse", int'(body_add), 0);
    dur = 0;
    saw_body = 1'b0;
    while (int'(status) == ST_E && dur < 100) begin
      if (body_add) saw_body = 1'b1;
      dur++;
      tick();
    end
    check_eq("end_hold_cycles", dur, HOLD);
    check_eq("end_no_pulse", int'(saw_body), 0);
    check_eq("end_to_start", int'(status), ST_S);

    enter_play("replay");
    eat_apple(1'b0);

    // Wall hit in the second cycle of a pulse aborts it and keeps the apple.
    ax = int'(apple_x);
    ay = int'(apple_y);
    do_step(ax, ay, 1'b0, 1'b0);
    check_eq("abort_pulse_rise", int'(body_add), 1);
    tick();
    do_step(ax, ay, 1'b1, 1'b0);
    check_eq("abort_status", int'(status), ST_E);
    check_eq("abort_body", int'(body_add), 0);
    check_eq("abort_valid", int'(apple_valid), 1);
    check_eq("abort_apple_x", int'(apple_x), ax);
    check_eq("abort_apple_y", int'(apple_y), ay);

    // A press in END returns to START before the hold expires.
    key_n = 1'b0;
    dur = 0;
    while (int'(status) == ST_E && dur < 100) begin
      dur++;
      tick();
    end
    check_eq("end_press_cycles", dur, lat0);
    check_eq("end_press_status", int'(status), ST_S);
    repeat (30) tick();
    check_eq("held_key_one_event", int'(status), ST_S);
    key_n = 1'b1;
    repeat (15) tick();

    enter_play("third");
    eat_apple(1'b0);
    do_step(int'(apple_x), int'(apple_y), 1'b0, 1'b0);
    check_eq("rst_pulse_rise", int'(body_add), 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_status", int'(status), ST_S);
    check_eq("midrst_body", int'(body_add), 0);
    check_eq("midrst_type", int'(apple_type), 0);
    check_eq("midrst_valid", int'(apple_valid), 1);
    check_eq("midrst_apple_x", int'(apple_x), 30);
    check_eq("midrst_apple_y", int'(apple_y), 15);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_status", int'(status), ST_S);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
